// File: rtl/exe_muldiv.sv
// exe_muldiv -- multi-cycle multiply/divide unit for the execute stage.
//
// Computes MULT/MULTU/DIV/DIVU into a HI/LO result pair. The multiplier has
// a configurable latency. The divider is an iterative radix-2 restoring
// divider that retires one quotient bit per clock.
//
// Build option: define EXE_MULDIV_DIV_EN to build the divider path (the DIV
// and FIX states). When it is undefined, DIV/DIVU complete in the cycle after
// accept with HI=LO=0, and div_by_zero is tied low.
//
// Parameters:
//   DATA_W   operand and HI/LO width (8..64)
//   MUL_LAT  multiply latency, in clock edges from accept to result (1..4)
// Ports:
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   flush        synchronous abort of the in-flight operation
//   op_valid     operation request; held high by the pipeline while stalled
//   op           0=MULT 1=MULTU 2=DIV 3=DIVU
//   src_a/src_b  operands, sampled only at accept
//   busy         combinational stall request toward the pipeline
//   res_valid    one-cycle result pulse, also the HI/LO write enable
//   hi_out       high product / remainder (registered, held)
//   lo_out       low product / quotient (registered, held)
//   div_by_zero  pulses with res_valid when the divisor was zero
module exe_muldiv #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              res_valid,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]          state_q, state_d;
  logic                signed_q, signed_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  // Magnitude of a two's-complement value when the op is signed, raw otherwise.
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? -x : x;
  endfunction

  logic [DATA_W-1:0]   abs_a, abs_b;
  logic                neg_res;
  logic [2*DATA_W-1:0] prod_mag, prod, mul_res;

  assign abs_a    = abs_val(a_q, signed_q);
  assign abs_b    = abs_val(b_q, signed_q);
  assign neg_res  = signed_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
  assign prod_mag = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
  assign prod     = neg_res ? -prod_mag : prod_mag;

  // The operands stay latched for the whole MUL state, so the product is
  // simply shifted through MUL_LAT-1 retiming stages before it is used.
  generate
    if (MUL_LAT > 1) begin : g_pipe
      logic [2*DATA_W-1:0] pipe_q [MUL_LAT-1];
      logic [2*DATA_W-1:0] pipe_d [MUL_LAT-1];
      always_comb begin
        pipe_d[0] = prod;
        for (int i = 1; i < MUL_LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end
      assign mul_res = pipe_q[MUL_LAT-2];
    end else begin : g_nopipe
      assign mul_res = prod;
    end
  endgenerate

`ifdef EXE_MULDIV_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic              dz_q, dz_d;
  logic [DATA_W:0]   shifted;
  logic              take;
  logic [DATA_W-1:0] rem_next, quo_next, quo_fix, rem_fix;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  assign shifted  = {rem_q, quo_q[DATA_W-1]};
  assign take     = (shifted >= {1'b0, abs_b});
  assign rem_next = take ? DATA_W'(shifted - {1'b0, abs_b}) : shifted[DATA_W-1:0];
  assign quo_next = {quo_q[DATA_W-2:0], take};

  // Sign fix-up: quotient negative when operand signs differ, remainder
  // follows the dividend.
  assign quo_fix  = neg_res ? -quo_q : quo_q;
  assign rem_fix  = (signed_q && a_q[DATA_W-1]) ? -rem_q : rem_q;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef EXE_MULDIV_DIV_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
    dz_d     = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          a_d      = src_a;
          b_d      = src_b;
          signed_d = ~op[0];
          cnt_d    = '0;
`ifdef EXE_MULDIV_DIV_EN
          dz_d     = 1'b0;
`endif
          if (!op[1]) begin
            state_d = S_MUL;
          end else begin
`ifdef EXE_MULDIV_DIV_EN
            state_d = S_DIV;
            rem_d   = '0;
            quo_d   = abs_val(src_a, ~op[0]);
            dz_d    = (src_b == '0);
`else
            state_d = S_DONE;
            hi_d    = '0;
            lo_d    = '0;
`endif
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          state_d = S_DONE;
          hi_d    = mul_res[2*DATA_W-1:DATA_W];
          lo_d    = mul_res[DATA_W-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef EXE_MULDIV_DIV_EN
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DIV_LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (dz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset clears everything, aborting any operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      signed_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef EXE_MULDIV_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef EXE_MULDIV_DIV_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dz_q     <= dz_d;
`endif
    end
  end

  // busy drops in DONE so the pipeline advances on that edge; it is forced
  // low during reset even if a request is being presented.
  assign busy = rstn & (((state_q == S_IDLE) & op_valid & ~flush) |
                        (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX));

  assign res_valid = (state_q == S_DONE) & ~flush;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
`ifdef EXE_MULDIV_DIV_EN
  assign div_by_zero = res_valid & dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_exe_muldiv.sv
// Testbench for exe_muldiv: two instances (MUL_LAT=1 and MUL_LAT=3, both
// DATA_W=32) driven with directed vectors and hand-computed expectations.
module tb_exe_muldiv;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        flush = 1'b0;
  logic        op_valid1 = 1'b0;
  logic        op_valid3 = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;

  logic        busy1, res_valid1, dz1;
  logic [31:0] hi1, lo1;
  logic        busy3, res_valid3, dz3;
  logic [31:0] hi3, lo3;

  int checks = 0;
  int errors = 0;

  exe_muldiv #(.DATA_W(32), .MUL_LAT(1)) dut1 (
    .clk(clk), .rstn(rstn), .flush(flush), .op_valid(op_valid1), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy1), .res_valid(res_valid1),
    .hi_out(hi1), .lo_out(lo1), .div_by_zero(dz1)
  );

  exe_muldiv #(.DATA_W(32), .MUL_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .flush(flush), .op_valid(op_valid3), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy3), .res_valid(res_valid3),
    .hi_out(hi3), .lo_out(lo3), .div_by_zero(dz3)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Present a request to one instance just after a falling edge.
  task automatic issue(input bit sel, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o;
    src_a = a;
    src_b = b;
    if (sel) op_valid3 = 1'b1;
    else op_valid1 = 1'b1;
    #1;
  endtask

  // Count busy cycles (accept cycle included) until busy falls, then report res_valid.
  task automatic wait_done(input bit sel, output int nbusy, output bit rv);
    bit done;
    nbusy = 0;
    rv = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (sel ? busy3 : busy1) begin
        nbusy++;
        @(negedge clk);
        #1;
      end else begin
        rv = sel ? res_valid3 : res_valid1;
        done = 1'b1;
      end
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    op_valid1 = 1'b0;
    op_valid3 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0;
    op_valid1 = 1'b1;
    op_valid3 = 1'b1;
    op = OP_DIVU;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy1: got %b expected 0", busy1); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy3: got %b expected 0", busy3); end
    checks++; if (hi1 !== 32'h0 || lo1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_hilo: got %h/%h expected 0/0", hi1, lo1); end
    checks++; if (res_valid1 !== 1'b0 || dz1 !== 1'b0 || res_valid3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b%b%b expected 000", res_valid1, dz1, res_valid3); end
    op_valid1 = 1'b0;
    op_valid3 = 1'b0;
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_mult();
    logic [1:0]  vo [4] = '{OP_MULT, OP_MULT, OP_MULTU, OP_MULT};
    logic [31:0] va [4] = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h80000000};
    logic [31:0] vb [4] = '{32'h00000003, 32'hFFFFFFFB, 32'h00000003, 32'h80000000};
    logic [31:0] eh [4] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000002, 32'h40000000};
    logic [31:0] el [4] = '{32'hFFFFFFFA, 32'h0000000F, 32'hFFFFFFFA, 32'h00000000};
    int nb;
    bit rv;
    for (int i = 0; i < 4; i++) begin
      issue(0, vo[i], va[i], vb[i]);
      wait_done(0, nb, rv);
      checks++; if (nb !== 2) begin errors++; $display("[TB] FAIL mult%0d_busy: got %0d cycles expected 2", i, nb); end
      checks++; if (rv !== 1'b1) begin errors++; $display("[TB] FAIL mult%0d_valid: got %b expected 1", i, rv); end
      checks++; if (hi1 !== eh[i] || lo1 !== el[i]) begin errors++; $display("[TB] FAIL mult%0d_result: got %h_%h expected %h_%h", i, hi1, lo1, eh[i], el[i]); end
      checks++; if (dz1 !== 1'b0) begin errors++; $display("[TB] FAIL mult%0d_dz: got %b expected 0", i, dz1); end
      release_op();
      checks++; if (res_valid1 !== 1'b0 || hi1 !== eh[i]) begin errors++; $display("[TB] FAIL mult%0d_pulse: got rv=%b hi=%h expected rv=0 hi=%h", i, res_valid1, hi1, eh[i]); end
    end
  endtask

  task automatic test_mul_latency3();
    int nb;
    bit rv;
    issue(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1, nb, rv);
    checks++; if (nb !== 4) begin errors++; $display("[TB] FAIL lat3_busy: got %0d cycles expected 4", nb); end
    checks++; if (rv !== 1'b1) begin errors++; $display("[TB] FAIL lat3_valid: got %b expected 1", rv); end
    checks++; if (hi3 !== 32'hFFFFFFFE || lo3 !== 32'h00000001) begin errors++; $display("[TB] FAIL lat3_multu: got %h_%h expected fffffffe_00000001", hi3, lo3); end
    release_op();
    issue(1, OP_MULT, 32'hFFFFFFF9, 32'h00000002);
    wait_done(1, nb, rv);
    checks++; if (nb !== 4 || rv !== 1'b1) begin errors++; $display("[TB] FAIL lat3_mult_timing: got %0d/%b expected 4/1", nb, rv); end
    checks++; if (hi3 !== 32'hFFFFFFFF || lo3 !== 32'hFFFFFFF2) begin errors++; $display("[TB] FAIL lat3_mult: got %h_%h expected ffffffff_fffffff2", hi3, lo3); end
    release_op();
  endtask

`ifdef EXE_MULDIV_DIV_EN
  task automatic test_divide();
    logic [1:0]  vo [6] = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIVU, OP_DIV, OP_DIV};
    logic [31:0] va [6] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFFB, 32'h80000000};
    logic [31:0] vb [6] = '{32'h00000002, 32'hFFFFFFFE, 32'h00000010, 32'd0, 32'd0, 32'hFFFFFFFF};
    logic [31:0] eh [6] = '{32'hFFFFFFFF, 32'h00000001, 32'h0000000F, 32'd100, 32'hFFFFFFFB, 32'h00000000};
    logic [31:0] el [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic        ez [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int nb;
    bit rv;
    for (int i = 0; i < 6; i++) begin
      issue(0, vo[i], va[i], vb[i]);
      wait_done(0, nb, rv);
      checks++; if (nb !== 34) begin errors++; $display("[TB] FAIL div%0d_busy: got %0d cycles expected 34", i, nb); end
      checks++; if (rv !== 1'b1) begin errors++; $display("[TB] FAIL div%0d_valid: got %b expected 1", i, rv); end
      checks++; if (hi1 !== eh[i] || lo1 !== el[i]) begin errors++; $display("[TB] FAIL div%0d_result: got hi=%h lo=%h expected hi=%h lo=%h", i, hi1, lo1, eh[i], el[i]); end
      checks++; if (dz1 !== ez[i]) begin errors++; $display("[TB] FAIL div%0d_dz: got %b expected %b", i, dz1, ez[i]); end
      release_op();
      checks++; if (dz1 !== 1'b0 || res_valid1 !== 1'b0) begin errors++; $display("[TB] FAIL div%0d_pulse: got dz=%b rv=%b expected 0/0", i, dz1, res_valid1); end
    end
  endtask

  task automatic test_div_flush();
    int pulses;
    issue(0, OP_DIVU, 32'd50, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    op_valid1 = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL divflush_busy: got %b expected 0", busy1); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL divflush_pulses: got %0d expected 0", pulses); end
    checks++; if (hi1 !== 32'h0 || lo1 !== 32'h80000000) begin errors++; $display("[TB] FAIL divflush_hold: got %h/%h expected 00000000/80000000", hi1, lo1); end
  endtask
`else
  task automatic test_div_disabled();
    int nb;
    bit rv;
    issue(0, OP_DIVU, 32'd100, 32'd0);
    wait_done(0, nb, rv);
    checks++; if (nb !== 1) begin errors++; $display("[TB] FAIL nodiv_busy: got %0d cycles expected 1", nb); end
    checks++; if (rv !== 1'b1) begin errors++; $display("[TB] FAIL nodiv_valid: got %b expected 1", rv); end
    checks++; if (hi1 !== 32'h0 || lo1 !== 32'h0 || dz1 !== 1'b0) begin errors++; $display("[TB] FAIL nodiv_result: got %h/%h dz=%b expected 0/0 dz=0", hi1, lo1, dz1); end
    release_op();
  endtask
`endif

  task automatic test_flush();
    int pulses;
    @(negedge clk);
    flush = 1'b1;
    op_valid1 = 1'b1;
    op = OP_MULT;
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL idleflush_busy: got %b expected 0", busy1); end
    @(negedge clk);
    flush = 1'b0;
    op_valid1 = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0 || res_valid1 !== 1'b0) begin errors++; $display("[TB] FAIL idleflush_noaccept: got busy=%b rv=%b expected 0/0", busy1, res_valid1); end
    issue(1, OP_MULT, 32'd5, 32'd6);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    op_valid3 = 1'b0;
    #1;
    checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL mulflush_busy: got %b expected 0", busy3); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid3) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL mulflush_pulses: got %0d expected 0", pulses); end
    checks++; if (hi3 !== 32'hFFFFFFFF || lo3 !== 32'hFFFFFFF2) begin errors++; $display("[TB] FAIL mulflush_hold: got %h_%h expected ffffffff_fffffff2", hi3, lo3); end
  endtask

  task automatic test_back_to_back();
    int nb;
    bit rv;
`ifdef EXE_MULDIV_DIV_EN
    int exp_nb = 34;
    logic [31:0] exp_hi = 32'd1;
    logic [31:0] exp_lo = 32'd2;
`else
    int exp_nb = 1;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;
`endif
    issue(0, OP_DIVU, 32'd9, 32'd4);
    wait_done(0, nb, rv);
    checks++; if (nb !== exp_nb || rv !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_timing: got %0d/%b expected %0d/1", nb, rv, exp_nb); end
    checks++; if (hi1 !== exp_hi || lo1 !== exp_lo) begin errors++; $display("[TB] FAIL b2b_first_result: got %h/%h expected %h/%h", hi1, lo1, exp_hi, exp_lo); end
    @(negedge clk);
    op = OP_MULT;
    src_a = 32'd20;
    src_b = 32'd3;
    #1;
    checks++; if (res_valid1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_next_accept: got rv=%b busy=%b expected 0/1", res_valid1, busy1); end
    wait_done(0, nb, rv);
    checks++; if (nb !== 2 || rv !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_timing: got %0d/%b expected 2/1", nb, rv); end
    checks++; if (hi1 !== 32'd0 || lo1 !== 32'd60) begin errors++; $display("[TB] FAIL b2b_second_result: got %h/%h expected 0/3c", hi1, lo1); end
    release_op();
  endtask

  task automatic test_reset_mid();
    int pulses;
`ifdef EXE_MULDIV_DIV_EN
    issue(0, OP_DIVU, 32'd50, 32'd7);
    repeat (5) @(negedge clk);
`endif
    issue(1, OP_MULTU, 32'd5, 32'd6);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b/%b expected 0/0", busy1, busy3); end
    checks++; if (hi1 !== 32'h0 || lo1 !== 32'h0 || hi3 !== 32'h0 || lo3 !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_hilo: got %h %h %h %h expected all 0", hi1, lo1, hi3, lo3); end
    @(negedge clk);
    op_valid1 = 1'b0;
    op_valid3 = 1'b0;
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid1 || res_valid3) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL rstmid_pulses: got %0d expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mul_latency3();
`ifdef EXE_MULDIV_DIV_EN
    test_divide();
    test_div_flush();
`else
    test_div_disabled();
`endif
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
